// File: rtl/uart_tx_fifo.sv
`default_nettype none
// uart_tx_fifo: FIFO-buffered UART transmitter with run-time divisor, parity and stop bits.
// Define UART_TX_FIFO_PARITY_EN to build the parity bit; without it frames carry no parity.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic [1:0]                    parity,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_d;
  logic                 ready_q, ready_d;
  logic                 push, pop, load, bit_tick;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_f_q, div_f_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop2_f_q, stop2_f_d;
  logic                 stop_second_q, stop_second_d;
  logic                 tx_q, tx_d;

`ifdef UART_TX_FIFO_PARITY_EN
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
`else
  logic                 unused_parity;
  assign unused_parity = ^parity;
`endif

  // FIFO bookkeeping: pointers carry a wrap bit so full and empty differ.
  assign push     = valid & ready_q;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign level    = wr_ptr_q - rd_ptr_q;
  assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign level_d  = wr_ptr_d - rd_ptr_d;
  assign ready_d  = (level_d != FULL_LEVEL);

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = (state_q != S_IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_f_d       = div_f_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    stop2_f_d     = stop2_f_q;
    stop_second_d = stop_second_q;
    tx_d          = tx_q;
    pop           = 1'b0;
    load          = 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
    par_en_d      = par_en_q;
    par_bit_d     = par_bit_q;
`endif
    bit_tick = (cnt_q == '0);
    if (state_q != S_IDLE) begin
      cnt_d = bit_tick ? div_f_q : cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (level != '0) load = 1'b1;
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_FIFO_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d       = S_STOP;
              tx_d          = 1'b1;
              stop_second_d = 1'b0;
            end
`else
            state_d       = S_STOP;
            tx_d          = 1'b1;
            stop_second_d = 1'b0;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          state_d       = S_STOP;
          tx_d          = 1'b1;
          stop_second_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (stop2_f_q && !stop_second_q) begin
            stop_second_d = 1'b1;
          end else if (level != '0) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: settings are captured here so later changes only affect the next frame.
    if (load) begin
      pop       = 1'b1;
      state_d   = S_START;
      tx_d      = 1'b0;
      cnt_d     = div;
      div_f_d   = div;
      stop2_f_d = stop2;
      shift_d   = head;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_d  = parity[1];
      par_bit_d = (^head) ^ parity[0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ready_q       <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_f_q       <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      stop2_f_q     <= 1'b0;
      stop_second_q <= 1'b0;
      tx_q          <= 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ready_q       <= ready_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_f_q       <= div_f_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      stop2_f_q     <= stop2_f_d;
      stop_second_q <= stop_second_d;
      tx_q          <= tx_d;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_q      <= par_en_d;
      par_bit_q     <= par_bit_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo: randomized and directed checks against a frame-level reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        valid, ready;
  logic [15:0] div;
  logic [1:0]  parity;
  logic        stop2, tx, busy;
  logic [2:0]  level;
  logic [4:0]  data5;
  logic        valid5, ready5, tx5, busy5;
  logic [15:0] div5;
  logic [2:0]  level5;

  int tests = 0;
  int fails = 0;

  logic [7:0] words[$];
  bit         bits[$];
  bit         m_tx, m_ready, m_busy;
  int         m_level;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .div(div), .parity(parity), .stop2(stop2), .tx(tx), .busy(busy), .level(level)
  );

  uart_tx_fifo #(.DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .data(data5), .valid(valid5), .ready(ready5),
    .div(div5), .parity(2'b00), .stop2(1'b0), .tx(tx5), .busy(busy5), .level(level5)
  );

  // Whole frame as a list of line levels, one entry per clock.
  function automatic void build_frame(input logic [7:0] w);
    bit         seq[$];
    int         per;
    logic [1:0] ep;
    per = int'(div) + 1;
`ifdef UART_TX_FIFO_PARITY_EN
    ep = parity;
`else
    ep = 2'b00;
`endif
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(w[i]);
    if (ep[1]) seq.push_back((($countones(w) % 2) == 1) ^ ep[0]);
    seq.push_back(1'b1);
    if (stop2) seq.push_back(1'b1);
    foreach (seq[i]) repeat (per) bits.push_back(seq[i]);
  endfunction

  function automatic void model_step();
    bit rb, ff;
    rb = m_ready;
    ff = 1'b0;
    if (bits.size() == 0 && words.size() > 0) build_frame(words.pop_front());
    if (valid && rb) words.push_back(data);
    if (bits.size() > 0) begin
      m_tx = bits.pop_front();
      ff   = 1'b1;
    end else begin
      m_tx = 1'b1;
    end
    m_level = words.size();
    m_ready = (m_level != DEPTH);
    m_busy  = ff || (m_level != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic model_clear();
    words.delete();
    bits.delete();
    m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_level = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; valid5 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
  endtask

  task automatic test_8n1();
    bit pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    div = 16'd3; parity = 2'b00; stop2 = 1'b0; data = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0;
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL a5_level got %0d want 1", level); end
    for (int j = 0; j < 44; j++) begin
      tick();
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL a5_model j=%0d tx/rdy/busy/lvl got %b%b%b/%0d want %b%b%b/%0d",
                 j, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
      if (j < 40) begin
        tests++; if (tx !== pat[j/4]) begin fails++; $display("FAIL a5_bit j=%0d got %b want %b", j, tx, pat[j/4]); end
      end
      tests++; if (busy !== (j < 40)) begin fails++; $display("FAIL a5_busy j=%0d got %b want %b", j, busy, j < 40); end
    end
  endtask

  task automatic test_parity();
    for (int mode = 2; mode <= 3; mode++) begin
      div = 16'd0; parity = 2'(mode); stop2 = 1'b0; data = 8'h07; valid = 1'b1;
      tick();
      valid = 1'b0;
      for (int j = 0; j < 14; j++) begin
        tick();
        tests++;
        if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
          fails++;
          $display("FAIL parity_model mode=%0d j=%0d got %b%b%b/%0d want %b%b%b/%0d",
                   mode, j, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
        end
`ifdef UART_TX_FIFO_PARITY_EN
        if (j == 9) begin
          tests++; if (tx !== (mode == 2)) begin fails++; $display("FAIL parity_bit mode=%0d got %b want %b", mode, tx, mode == 2); end
        end
        if (j == 10 || j == 11) begin
          tests++; if (busy !== (j == 10)) begin fails++; $display("FAIL parity_len j=%0d busy got %b want %b", j, busy, j == 10); end
        end
`else
        if (j == 9 || j == 10) begin
          tests++; if (busy !== (j == 9)) begin fails++; $display("FAIL noparity_len j=%0d busy got %b want %b", j, busy, j == 9); end
        end
`endif
      end
    end
    parity = 2'b00;
  endtask

  task automatic test_back_to_back();
    int n = 0, drop_at = -1, cnt = 0;
    bit acc, started = 1'b0, done = 1'b0;
    div = 16'd1; parity = 2'b00; stop2 = 1'b0; data = 8'h01; valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      acc = valid && ready;
      tick();
      if (acc) begin
        n++;
        data = 8'(n + 1);
        if (n == 6) valid = 1'b0;
      end
      if (!ready && drop_at < 0) drop_at = n;
      if (!started && tx == 1'b0) started = 1'b1;
      if (started && busy) cnt++;
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL b2b_model i=%0d got %b%b%b/%0d want %b%b%b/%0d",
                 i, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
      done = (n == 6) && (bits.size() == 0) && (words.size() == 0) && !busy;
    end
    tests++; if (!done) begin fails++; $display("FAIL b2b_timeout n=%0d want 6", n); end
    tests++; if (drop_at !== 5) begin fails++; $display("FAIL b2b_ready_drop got %0d want 5", drop_at); end
    tests++; if (cnt !== 120) begin fails++; $display("FAIL b2b_busy_span got %0d want 120", cnt); end
  endtask

  task automatic test_stop2();
    int cnt = 0;
    bit want;
    div = 16'd1; parity = 2'b00; stop2 = 1'b1; data = 8'h55; valid = 1'b1;
    tick();
    data = 8'h01;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (j == 0) valid = 1'b0;
      if (j == 3) div = 16'd5;
      if (busy) cnt++;
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL stop2_model j=%0d got %b%b%b/%0d want %b%b%b/%0d",
                 j, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
      if (j >= 16 && j <= 28) begin
        want = (j >= 18 && j <= 21) || (j == 28);
        tests++; if (tx !== want) begin fails++; $display("FAIL stop2_gap j=%0d got %b want %b", j, tx, want); end
      end
    end
    tests++; if (cnt !== 88) begin fails++; $display("FAIL stop2_span got %0d want 88", cnt); end
    div = 16'd0; stop2 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit done = 1'b0;
    div = 16'd2; parity = 2'b00; stop2 = 1'b0; data = 8'hF0;
    for (int j = -1; j <= 10; j++) begin
      valid = (j < 3);
      if (j >= 0) data = 8'($urandom);
      tick();
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL rstmid_model j=%0d got %b%b%b/%0d want %b%b%b/%0d",
                 j, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
    end
    #3 rst = 1'b1;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", tx); end
    @(posedge clk); @(posedge clk); #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", ready); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL rstmid_level got %0d want 0", level); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    model_clear();
    rst = 1'b0;
    div = 16'd1; data = 8'($urandom); valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int j = 0; j < 60 && !done; j++) begin
      tick();
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL rstmid_after j=%0d got %b%b%b/%0d want %b%b%b/%0d",
                 j, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
      if (j == 0) begin
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL rstmid_latency got %b want 0", tx); end
      end
      done = !busy && (j > 0);
    end
    tests++; if (!done) begin fails++; $display("FAIL rstmid_timeout busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    int  errs = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(2) == 0);
      data  = 8'($urandom);
      if ($urandom_range(30) == 0) begin
        div    = 16'($urandom_range(3));
        parity = 2'($urandom);
        stop2  = 1'($urandom);
      end
      tick();
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++; errs++;
        if (errs < 20)
          $display("FAIL random i=%0d got %b%b%b/%0d want %b%b%b/%0d",
                   i, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
    end
    valid = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      tests++;
      if ({tx, ready, busy, level} !== {m_tx, m_ready, m_busy, 3'(m_level)}) begin
        fails++;
        $display("FAIL random_drain i=%0d got %b%b%b/%0d want %b%b%b/%0d",
                 i, tx, ready, busy, level, m_tx, m_ready, m_busy, m_level);
      end
      done = !m_busy;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL random_timeout busy=%b want 0", busy); end
    div = 16'd0; parity = 2'b00; stop2 = 1'b0;
  endtask

  task automatic test_five_bits();
    div5 = 16'd0; data5 = 5'h1F; valid5 = 1'b1;
    @(posedge clk); #1;
    valid5 = 1'b0;
    tests++; if (level5 !== 3'd1) begin fails++; $display("FAIL five_level got %0d want 1", level5); end
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      tests++; if (tx5 !== (j != 0)) begin fails++; $display("FAIL five_tx j=%0d got %b want %b", j, tx5, j != 0); end
      tests++; if (busy5 !== (j < 7)) begin fails++; $display("FAIL five_busy j=%0d got %b want %b", j, busy5, j < 7); end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00; div = 16'd0; parity = 2'b00; stop2 = 1'b0;
    valid5 = 1'b0; data5 = 5'h00; div5 = 16'd0;
    do_reset();
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_reset_midframe();
    test_random();
    test_five_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
